// File: rtl/grc_pkg.sv
// Shared types and constants for the gate response checker.
package grc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StCheck,
      StDone
   } grc_state_e;

   // x^8 + x^6 + x^5 + x^4 + 1 (x^8 implicit)
   localparam logic [7:0] GrcMisrPoly = 8'h71;

   // Expected s indexed by {a,b}
   localparam logic [3:0] TblAnd  = 4'h8;
   localparam logic [3:0] TblOr   = 4'hE;
   localparam logic [3:0] TblXor  = 4'h6;
   localparam logic [3:0] TblNand = 4'h7;
   localparam logic [3:0] TblNor  = 4'h1;
   localparam logic [3:0] TblXnor = 4'h9;

   // One MISR step: shift left, fold the polynomial in on MSB carry-out, xor data in.
   function automatic logic [7:0] grc_misr_step(input logic [7:0] sig, input logic [7:0] din);
      grc_misr_step = {sig[6:0], 1'b0} ^ (sig[7] ? GrcMisrPoly : 8'h00) ^ din;
   endfunction

endpackage

// File: rtl/grc_misr.sv
// 8-bit multiple-input signature register with synchronous clear and enable.
module grc_misr
   import grc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] din,
   output logic [7:0] signature
);

   logic [7:0] sig_q, sig_d;

   // Clear wins over enable; otherwise hold.
   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = 8'h00;
      end else if (enable) begin
         sig_d = grc_misr_step(sig_q, din);
      end
   end

   // Signature register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q <= 8'h00;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;

endmodule

// File: rtl/gate_response_checker.sv
// Checks (a,b,s) samples from a 2-input gate against a latched 4-entry truth table and
// reports mismatch count, input coverage, first failing input and a pass/fail verdict.
// Optional: define GRC_MISR_EN to add an 8-bit response signature output.
module gate_response_checker
   import grc_pkg::*;
#(
   parameter int unsigned N_VEC   = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       truth_tbl,
   input  logic             in_valid,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_s,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       coverage,
   output logic [1:0]       first_err
`ifdef GRC_MISR_EN
   ,
   output logic [7:0]       signature
`endif
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TimeoutVal = TW'(TIMEOUT);
   localparam logic [CNT_W-1:0] VecLast    = CNT_W'(N_VEC);

   grc_state_e       state_q, state_d;
   logic [3:0]       tbl_q, tbl_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic [TW-1:0]    idle_q, idle_d;
   logic [3:0]       cov_q, cov_d;
   logic [1:0]       fe_q, fe_d;
   logic             pass_q, pass_d;
   logic             to_q, to_d;

   logic       accept;
   logic       start_acc;
   logic [1:0] idx;
   logic       mismatch;

   assign in_ready  = (state_q == StRun);
   assign accept    = in_valid & in_ready;
   assign start_acc = start & ((state_q == StIdle) | (state_q == StDone));
   assign idx       = {in_a, in_b};
   assign mismatch  = in_s ^ tbl_q[idx];

   // Next-state: run setup on start, per-accept bookkeeping, idle timeout, verdict.
   always_comb begin
      state_d = state_q;
      tbl_d   = tbl_q;
      err_d   = err_q;
      vec_d   = vec_q;
      idle_d  = idle_q;
      cov_d   = cov_q;
      fe_d    = fe_q;
      pass_d  = pass_q;
      to_d    = to_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_acc) begin
               state_d = StRun;
               tbl_d   = truth_tbl;
               err_d   = '0;
               vec_d   = '0;
               idle_d  = '0;
               cov_d   = 4'h0;
               fe_d    = 2'b00;
               pass_d  = 1'b0;
               to_d    = 1'b0;
            end
         end
         StRun: begin
            if (accept) begin
               // An accept always clears the idle timer, so it beats a coincident timeout.
               idle_d     = '0;
               cov_d[idx] = 1'b1;
               vec_d      = vec_q + CNT_W'(1);
               if (mismatch) begin
                  if (err_q != '1) begin
                     err_d = err_q + CNT_W'(1);
                  end
                  if (err_q == '0) begin
                     fe_d = idx;
                  end
               end
               if (vec_q + CNT_W'(1) == VecLast) begin
                  state_d = StCheck;
               end
            end else begin
               idle_d = idle_q + TW'(1);
               if (idle_q + TW'(1) == TimeoutVal) begin
                  to_d    = 1'b1;
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            pass_d  = (err_q == '0) & (cov_q == 4'hF) & ~to_q;
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         tbl_q   <= 4'h0;
         err_q   <= '0;
         vec_q   <= '0;
         idle_q  <= '0;
         cov_q   <= 4'h0;
         fe_q    <= 2'b00;
         pass_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tbl_q   <= tbl_d;
         err_q   <= err_d;
         vec_q   <= vec_d;
         idle_q  <= idle_d;
         cov_q   <= cov_d;
         fe_q    <= fe_d;
         pass_q  <= pass_d;
         to_q    <= to_d;
      end
   end

   assign busy      = (state_q == StRun) | (state_q == StCheck);
   assign done      = (state_q == StDone);
   assign pass      = pass_q;
   assign timeout   = to_q;
   assign err_count = err_q;
   assign coverage  = cov_q;
   assign first_err = fe_q;

`ifdef GRC_MISR_EN
   grc_misr u_misr (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_acc),
      .enable    (accept),
      .din       ({5'b00000, in_a, in_b, in_s}),
      .signature (signature)
   );
`endif

endmodule
